// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and a magnitude/negate helper.
package mdu_pkg;

  localparam logic [4:0] MDU_MUL    = 5'd17;
  localparam logic [4:0] MDU_MULH   = 5'd18;
  localparam logic [4:0] MDU_MULHU  = 5'd19;
  localparam logic [4:0] MDU_DIV    = 5'd20;
  localparam logic [4:0] MDU_DIVU   = 5'd21;
  localparam logic [4:0] MDU_REM    = 5'd22;
  localparam logic [4:0] MDU_REMU   = 5'd23;
  localparam logic [4:0] MDU_MULHSU = 5'd24;

  // Widest supported operand; the helper works at this width and callers
  // truncate back to their own width.
  localparam int MDU_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Two's-complement negate when neg is set, pass-through otherwise.
  // Used both to take magnitudes at accept and to re-apply signs at the end.
  function automatic logic [MDU_MAX_W-1:0] abs_val(input logic [MDU_MAX_W-1:0] v,
                                                   input logic                 neg);
    return neg ? (~v + MDU_MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference if it
// did not borrow.
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] divisor,
  input  logic            bit_in,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // Trial subtraction; the borrow bit decides the quotient bit.
  // NOTE: combinational logic uses blocking '=' and assigns every output on every path, so no latch is inferred.
  always_comb begin
    shifted = {rem_in, bit_in};
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[XLEN];
    rem_out = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle RV M-extension multiply/divide unit with valid/ready handshake.
// Divide is radix-2 restoring on magnitudes; multiply is radix-2 shift-add
// unless FAST_MUL_EN is defined, in which case multiplies finish in one cycle.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int PW = 2 * XLEN;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       op_q;
  logic             q_neg_q;     // quotient must be negated at the end
  logic             r_neg_q;     // remainder must be negated at the end
  logic             b_signed_q;  // multiplier MSB carries negative weight
  logic [PW-1:0]    acc_q;       // product accumulator / partial remainder
  logic [PW-1:0]    mcand_q;     // shifting multiplicand / divisor magnitude
  logic [XLEN-1:0]  work_q;      // multiplier bits / dividend->quotient bits
  logic [XLEN-1:0]  res_q;

  // Request decode
  logic            accept;
  logic            is_mul_in, is_div_in, div_signed;
  logic            s1_neg, s2_neg, a_signed, b_signed_in;
  logic            div_zero, div_ovf, go_done;
  logic [XLEN-1:0] s1_abs, s2_abs, special_res;
  logic [PW-1:0]   a_ext;
`ifdef FAST_MUL_EN
  logic [PW-1:0]   b_ext, fast_prod;
`endif

  // Iteration datapath
  logic            last_step, mul_op_q;
  logic [PW-1:0]   mul_sum, acc_mul_next;
  logic [XLEN-1:0] rem_next, quo_fin, quo_signed, rem_signed, final_res;
  logic            q_bit;

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (acc_q[XLEN-1:0]),
    .divisor (mcand_q[XLEN-1:0]),
    .bit_in  (work_q[XLEN-1]),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // Classify the incoming request and resolve the cases that skip iteration.
  always_comb begin
    is_mul_in   = op inside {MDU_MUL, MDU_MULH, MDU_MULHU, MDU_MULHSU};
    is_div_in   = op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
    div_signed  = (op == MDU_DIV) || (op == MDU_REM);
    s1_neg      = div_signed && src1[XLEN-1];
    s2_neg      = div_signed && src2[XLEN-1];
    s1_abs      = XLEN'(abs_val(MDU_MAX_W'($signed(src1)), s1_neg));
    s2_abs      = XLEN'(abs_val(MDU_MAX_W'($signed(src2)), s2_neg));
    a_signed    = (op == MDU_MULH) || (op == MDU_MULHSU);
    b_signed_in = (op == MDU_MULH);
    a_ext       = {{XLEN{a_signed && src1[XLEN-1]}}, src1};
    div_zero    = is_div_in && (src2 == '0);
    div_ovf     = div_signed && (src1 == MOST_NEG) && (src2 == '1);
`ifdef FAST_MUL_EN
    b_ext       = {{XLEN{b_signed_in && src2[XLEN-1]}}, src2};
    fast_prod   = a_ext * b_ext;
`endif
    go_done     = 1'b0;
    special_res = '0;
    if (!is_mul_in && !is_div_in) begin
      go_done = 1'b1;
    end else if (div_zero) begin
      go_done     = 1'b1;
      special_res = ((op == MDU_DIV) || (op == MDU_DIVU)) ? '1 : src1;
    end else if (div_ovf) begin
      go_done     = 1'b1;
      special_res = (op == MDU_DIV) ? src1 : '0;
    end
`ifdef FAST_MUL_EN
    else if (is_mul_in) begin
      go_done     = 1'b1;
      special_res = (op == MDU_MUL) ? fast_prod[XLEN-1:0] : fast_prod[PW-1:XLEN];
    end
`endif
  end

  // Per-cycle multiply/divide step and sign fix-up of the final result.
  always_comb begin
    last_step    = (state_q == CALC) && (cnt_q == CNT_W'(1));
    mul_op_q     = op_q inside {MDU_MUL, MDU_MULH, MDU_MULHU, MDU_MULHSU};
    // The multiplier's top bit has weight -2^(XLEN-1) when it is signed.
    mul_sum      = (last_step && b_signed_q) ? (acc_q - mcand_q) : (acc_q + mcand_q);
    acc_mul_next = work_q[0] ? mul_sum : acc_q;
    quo_fin      = {work_q[XLEN-2:0], q_bit};
    quo_signed   = XLEN'(abs_val(MDU_MAX_W'(quo_fin), q_neg_q));
    rem_signed   = XLEN'(abs_val(MDU_MAX_W'(rem_next), r_neg_q));
    case (op_q)
      MDU_MUL:                         final_res = acc_mul_next[XLEN-1:0];
      MDU_MULH, MDU_MULHU, MDU_MULHSU: final_res = acc_mul_next[PW-1:XLEN];
      MDU_DIV, MDU_DIVU:               final_res = quo_signed;
      default:                         final_res = rem_signed;
    endcase
  end

  // Next-state and handshake outputs; flush overrides every transition.
  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    accept    = in_valid && in_ready && !flush;
    unique case (state_q)
      IDLE:    if (accept)    state_d = go_done ? DONE : CALC;
      CALC:    if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // State register.
  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand latch at accept, then one shift-add or divide step per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      op_q       <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      b_signed_q <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      work_q     <= '0;
      res_q      <= '0;
    end else if (accept) begin
      cnt_q      <= CNT_W'(XLEN);
      op_q       <= op;
      q_neg_q    <= s1_neg ^ s2_neg;
      r_neg_q    <= s1_neg;
      b_signed_q <= b_signed_in;
      acc_q      <= '0;
      if (is_mul_in) begin
        mcand_q <= a_ext;
        work_q  <= src2;
      end else begin
        mcand_q <= PW'(s2_abs);
        work_q  <= s1_abs;
      end
      if (go_done) res_q <= special_res;
    end else if ((state_q == CALC) && !flush) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (mul_op_q) begin
        acc_q   <= acc_mul_next;
        mcand_q <= mcand_q << 1;
        work_q  <= work_q >> 1;
      end else begin
        acc_q  <= PW'(rem_next);
        work_q <= quo_fin;
      end
      if (last_step) res_q <= final_res;
    end
  end

  assign result = res_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: the driver pushes expected results from an
// arithmetic reference model, a monitor pops and compares on out_valid, and a
// responder applies back-pressure on out_ready.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN32 = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  op = '0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    int          stall;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];

  mdu_iter #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour straight from the M-extension arithmetic rules.
  function automatic logic [31:0] ref_model(input logic [4:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    int          sa, sbv;
    longint      p;
    logic [63:0] up;
    logic [31:0] r;
    sa  = $signed(a);
    sbv = $signed(b);
    up  = {32'b0, a} * {32'b0, b};
    r   = '0;
    case (o)
      MDU_MUL:    r = up[31:0];
      MDU_MULHU:  r = up[63:32];
      MDU_MULH:   begin p = longint'(sa) * longint'(sbv);        r = p[63:32]; end
      MDU_MULHSU: begin p = longint'(sa) * longint'({32'b0, b}); r = p[63:32]; end
      MDU_DIV:    if (b == 0) r = '1;
                  else if (a == MIN32 && b == '1) r = a;
                  else r = 32'(sa / sbv);
      MDU_REM:    if (b == 0) r = a;
                  else if (a == MIN32 && b == '1) r = '0;
                  else r = 32'(sa % sbv);
      MDU_DIVU:   r = (b == 0) ? '1 : a / b;
      MDU_REMU:   r = (b == 0) ? a : a % b;
      default:    r = '0;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    bit is_mul, is_div;
    is_mul = o inside {MDU_MUL, MDU_MULH, MDU_MULHU, MDU_MULHSU};
    is_div = o inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
    if (!is_mul && !is_div) return 1;
    if (is_div && b == 0) return 1;
    if ((o == MDU_DIV || o == MDU_REM) && a == MIN32 && b == '1) return 1;
`ifdef FAST_MUL_EN
    if (is_mul) return 1;
`endif
    return XLEN + 1;
  endfunction

  // Present a request, wait (bounded) for the handshake, then scramble the
  // operand pins so the DUT must rely on its latched copies.
  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input int stall, input bit track);
    int   budget;
    exp_t t;
    @(negedge clk);
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    budget = 0;
    while (!in_ready && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    src1 = $urandom;
    src2 = $urandom;
    if (track) begin
      t.op = o; t.a = a; t.b = b; t.res = e;
      t.lat = exp_lat(o, a, b); t.stall = stall; t.acc_cyc = cyc;
      sb.push_back(t);
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((sb.size() != 0 || busy) && b < 500) begin
      @(negedge clk);
      b++;
    end
    if (sb.size() != 0 || busy) check("drain_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return MIN32;
      3:       return 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // Responder: drives out_ready after each edge, stalling per transaction.
  int stall_left = 0;
  bit prev_ov = 1'b0;
  initial forever begin
    @(posedge clk);
    #3;
    if (out_valid) begin
      if (!prev_ov) stall_left = (sb.size() > 0) ? sb[0].stall : 0;
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
    end else begin
      out_ready = 1'b0;
    end
    prev_ov = out_valid;
  end

  // Monitor: compares every presented result against the scoreboard head.
  bit seen = 1'b0;
  bit exp_idle = 1'b0;
  int lat_obs;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (exp_idle) begin
        check("in_ready_after_handshake", 64'(in_ready), 64'd1);
        check("out_valid_after_handshake", 64'(out_valid), 64'd0);
        exp_idle = 1'b0;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          if (!seen) begin
            lat_obs = cyc - sb[0].acc_cyc + 1;
            check($sformatf("op%0d_latency", sb[0].op), 64'(lat_obs), 64'(sb[0].lat));
            check($sformatf("op%0d_result a=%0h b=%0h", sb[0].op, sb[0].a, sb[0].b),
                  64'(result), 64'(sb[0].res));
            seen = 1'b1;
          end else begin
            check("result_stable", 64'(result), 64'(sb[0].res));
          end
          check("in_ready_low_in_done", 64'(in_ready), 64'd0);
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
            exp_idle = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    logic [4:0]  ro;
    logic [31:0] ra, rb;
    int          k;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    rst_n = 1'b1;

    // Directed cases
    issue(MDU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0, 1);
    issue(MDU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0, 1);
    issue(MDU_DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, 0, 1);
    issue(MDU_REMU,   32'd100,       32'd0,         32'd100,       0, 1);
    issue(MDU_DIV,    MIN32,         32'hFFFF_FFFF, MIN32,         0, 1);
    issue(MDU_REM,    MIN32,         32'hFFFF_FFFF, 32'd0,         0, 1);
    issue(MDU_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 0, 1);
    issue(MDU_MULHU,  32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 0, 1);
    issue(MDU_MULH,   32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 0, 1);
    issue(MDU_MUL,    32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 0, 1);
    issue(5'd3,       32'd5,         32'd6,         32'd0,         0, 1);

    // Back-pressure: 5 stalled cycles, then an immediate follow-up request
    issue(MDU_DIVU, 32'd1000, 32'd7, 32'd142, 5, 1);
    issue(MDU_DIVU, 32'd9,    32'd4, 32'd2,   0, 1);
    drain();

    // Flush at cycle 10 of a divide: no result, unit idle next cycle
    issue(MDU_DIVU, 32'd1000, 32'd7, 32'd0, 0, 0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    flush = 1'b0;
    repeat (40) @(negedge clk);
    issue(MDU_DIVU, 32'd9, 32'd4, 32'd2, 0, 1);
    drain();

    // Flush with a request in IDLE blocks the accept
    @(negedge clk);
    op = MDU_DIVU; src1 = 32'd9; src2 = 32'd4; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_blocks_accept", 64'(busy), 64'd0);
    in_valid = 1'b0;
    flush = 1'b0;

    // Asynchronous reset mid-CALC
    issue(MDU_DIVU, 32'd1000, 32'd3, 32'd0, 0, 0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(0, 9);
      ro = (k < 8) ? 5'(17 + k) : 5'($urandom_range(0, 31));
      ra = pick();
      rb = pick();
      issue(ro, ra, rb, ref_model(ro, ra, rb),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
